// File: rtl/knn_vote.sv
// knn_vote: majority vote over the K nearest (distance, type) candidates from the sorter.
// Optional distance-order checking is enabled by defining KNN_VOTE_ORDER_CHECK_EN.
module knn_vote #(
    parameter int W         = 16,
    parameter int K         = 5,
    parameter int N_CLASSES = 4,
    localparam int CW       = $clog2(K + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_dist,
    input  logic [W-1:0]  in_type,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_class,
    output logic [CW-1:0] out_votes,
    output logic          out_type_err,
    output logic          out_order_err,
    output logic          busy
);

    // state   | meaning
    // COLLECT | counting votes of the first K candidates
    // DRAIN   | discarding candidates after the K-th until in_last
    // VOTE    | scanning one class per cycle for the winner
    // OUT     | holding the result until downstream accepts it
    typedef enum logic [1:0] {COLLECT, DRAIN, VOTE, OUT} state_t;

    localparam int SW = $clog2(N_CLASSES);

    state_t          state, state_nxt;
    logic [CW-1:0]   r;
    logic [CW-1:0]   cnt   [N_CLASSES];
    logic [CW-1:0]   first [N_CLASSES];
    logic [SW-1:0]   scan;
    logic [W-1:0]    best_class;
    logic [CW-1:0]   best_votes;
    logic [CW-1:0]   best_rank;
    logic            type_err;
    logic            order_err;

    logic            xfer_in;
    logic            type_ok;
    logic [SW-1:0]   type_idx;
    logic            scan_last;
    logic            cand_better;
    logic            clear;

    assign xfer_in   = in_valid & in_ready;
    assign type_ok   = {1'b0, in_type} < (W + 1)'(N_CLASSES);
    assign type_idx  = in_type[SW-1:0];
    assign scan_last = (scan == SW'(N_CLASSES - 1));
    assign clear     = rst | ((state == OUT) & out_ready);

    // Ties go to the class whose first member arrived earliest (nearest neighbour).
    assign cand_better = (cnt[scan] > best_votes) ||
                         ((cnt[scan] == best_votes) && (cnt[scan] != '0) &&
                          (first[scan] < best_rank));

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (xfer_in) begin
                if (in_last)                state_nxt = VOTE;
                else if (r == CW'(K - 1))   state_nxt = DRAIN;
            end
            DRAIN:   if (xfer_in && in_last) state_nxt = VOTE;
            VOTE:    if (scan_last)          state_nxt = OUT;
            OUT:     if (out_ready)          state_nxt = COLLECT;
            default:                         state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        in_ready      = (state == COLLECT) || (state == DRAIN);
        out_valid     = (state == OUT);
        out_class     = out_valid ? best_class : '0;
        out_votes     = out_valid ? best_votes : '0;
        out_type_err  = out_valid & type_err;
        out_order_err = out_valid & order_err;
        busy          = !((state == COLLECT) && (r == '0));
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r          <= '0;
            scan       <= '0;
            best_class <= '0;
            best_votes <= '0;
            best_rank  <= CW'(K);
            type_err   <= 1'b0;
            for (int c = 0; c < N_CLASSES; c++) begin
                cnt[c]   <= '0;
                first[c] <= CW'(K);
            end
        end else begin
            if (state == COLLECT && xfer_in) begin
                r <= r + CW'(1);
                if (type_ok) begin
                    cnt[type_idx] <= cnt[type_idx] + CW'(1);
                    if (first[type_idx] == CW'(K)) first[type_idx] <= r;
                end else begin
                    type_err <= 1'b1;
                end
            end
            if (state == VOTE) begin
                scan <= scan_last ? '0 : scan + SW'(1);
                if (cand_better) begin
                    best_class <= W'(scan);
                    best_votes <= cnt[scan];
                    best_rank  <= first[scan];
                end
            end
        end
    end

`ifdef KNN_VOTE_ORDER_CHECK_EN
    logic [W-1:0] prev_dist;

    always_ff @(posedge clk) begin
        if (clear) begin
            order_err <= 1'b0;
            prev_dist <= '0;
        end else if (xfer_in) begin
            prev_dist <= in_dist;
            // The first entry of a query has no predecessor to compare against.
            if (!(state == COLLECT && r == '0) && (in_dist < prev_dist))
                order_err <= 1'b1;
        end
    end
`else
    logic unused_dist;
    assign unused_dist = ^in_dist;
    assign order_err   = 1'b0;
`endif

endmodule

// File: doc/knn_vote.md
Name: knn_vote

Overview:
- Consumer end of the KNN sorting network. Takes the stream of (distance, type) candidates leaving the sorter in ascending distance order.
- Majority-votes the types of the first K entries and returns the predicted class.
- Entries after the K-th are drained and ignored until the stream ends.
- Sits between the sort stage and the classification result register.

Parameters:
- W, 16, width of distance and type fields (same W as the sorter).
- K, 5, number of nearest neighbours that vote (K ≥ 1).
- N_CLASSES, 4, number of valid class ids 0..N_CLASSES-1 (N_CLASSES ≥ 2, N_CLASSES ≤ 2^W).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  candidate valid
- in_ready  out  1  block accepts candidate
- in_dist  in  W  candidate distance
- in_type  in  W  candidate class id
- in_last  in  1  final candidate of this query
- out_valid  out  1  result valid
- out_ready  in  1  result accepted downstream
- out_class  out  W  winning class id
- out_votes  out  CW  votes for the winner, where CW = $clog2(K+1)
- out_type_err  out  1  at least one voting entry had in_type ≥ N_CLASSES
- out_order_err  out  1  distance order violation (see Optional Feature)
- busy  out  1  high in every state except COLLECT with zero entries taken

Behaviour:
- Reset clears all state and counters and enters COLLECT.
  - All outputs are 0, except in_ready = 1.
  - Reset mid-query discards the query; no result is produced.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Once out_valid is asserted, out_* stay stable until transfer.
- State COLLECT (in_ready = 1):
  - Each transfer increments rank r, which starts at 0.
  - If in_type < N_CLASSES: cnt[in_type]++. If first[in_type] == K (sentinel), set first[in_type] = r.
  - Otherwise set type_err and do not count the entry.
  - Transitions:
    - Transfer with in_last → VOTE.
    - Else, the K-th transfer → DRAIN.
- State DRAIN (in_ready = 1):
  - Transfers are accepted and ignored.
  - Transfer with in_last → VOTE.
- State VOTE (in_ready = 0):
  - Scans classes c = 0..N_CLASSES-1, one per cycle.
  - best starts at class 0, votes 0, rank K.
  - Class c replaces best if cnt[c] > best_votes, or if cnt[c] == best_votes, cnt[c] > 0 and first[c] < best_rank.
  - Tie rule: among tied counts, the class with the nearest member wins.
  - After the N_CLASSES-th scan cycle → OUT.
- State OUT:
  - out_valid = 1; out_class / out_votes = best; err flags are registered.
  - in_ready = 0.
  - On transfer: clear cnt, first, r and flags; go to COLLECT.
- Latency: last input transfer at cycle t gives out_valid at t + N_CLASSES + 1.
- Stream shorter than K: vote uses the entries received.
- All entries out of range: out_class = 0, out_votes = 0, out_type_err = 1.
- The K-th entry carrying in_last goes directly to VOTE and skips DRAIN.
- Counters are CW bits wide and cannot overflow, since at most K entries count.

Optional Feature:
- Macro: KNN_VOTE_ORDER_CHECK_EN.
- With the macro defined:
  - The previous accepted distance is stored in COLLECT and DRAIN.
  - Any transfer with in_dist < prev sets order_err. This is an unsigned compare; equal distances are legal.
  - The comparison is not made on the first entry of a query.
  - out_order_err reports the flag in OUT; the flag clears with the other state.
- Without the macro: out_order_err is tied to 0 and no distance register exists.

Test Plan:
- Defaults throughout.
1. Tie-break and drain: types 2,1,2,3,1 with dists 1..5, then types 0,0 with dists 6,7, last on 7.
   - Expect out_class = 2, out_votes = 2 (tie with class 1, class 2 is nearer).
   - Expect out_valid 5 cycles after the last transfer.
2. Short stream: types 3,3,0, last on the 3rd entry.
   - Expect out_class = 3, out_votes = 2.
   - Expect in_ready = 0 from the cycle after last until the output transfer.
3. Backpressure: hold out_ready = 0 for 10 cycles in OUT.
   - Expect out_valid = 1 with out_class / out_votes stable; in_ready = 0.
   - Expect return to COLLECT on the cycle after out_ready = 1.
4. Out-of-range type: types 7,1,1,7,0.
   - Expect out_class = 1, out_votes = 2, out_type_err = 1.
   - Expect out_type_err = 0 on the next clean query.
5. Reset mid-query: accept 2 entries, pulse rst, then send types 1,1,1,0,0.
   - Expect no result for the aborted query.
   - Expect out_class = 1, out_votes = 3.
6. Order check: dists 5,3,8, types 0,0,1.
   - Expect out_order_err = 1 with KNN_VOTE_ORDER_CHECK_EN, 0 without.
   - Expect out_class = 0 either way.
